// File: rtl/fix_pkg.sv
// Shared types and helpers for the FIX connection scheduler.
package fix_pkg;

    localparam int NUM_HOSTS = 4;

    typedef logic [1:0] host_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONN = 2'd1,
        WAIT = 2'd2,
        DISC = 2'd3
    } sched_state_t;

    // One-hot host mask for a host index.
    function automatic logic [NUM_HOSTS-1:0] host_onehot(input host_addr_t idx);
        return 4'b0001 << idx;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic host_addr_t lowest_set(input logic [NUM_HOSTS-1:0] mask);
        host_addr_t idx;
        idx = 2'd0;
        for (int i = NUM_HOSTS - 1; i >= 0; i--) begin
            idx = mask[i] ? host_addr_t'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fix_rr_pick.sv
// Combinational 4-way round-robin picker: first set mask bit at or after ptr,
// wrapping from host 3 back to host 0.
module fix_rr_pick
    import fix_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] index
);

    host_addr_t cand_s;

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        valid  = 1'b0;
        index  = 2'd0;
        cand_s = 2'd0;
        for (int k = NUM_HOSTS - 1; k >= 0; k--) begin
            cand_s = ptr + host_addr_t'(k);
            valid  = valid | mask[cand_s];
            index  = mask[cand_s] ? cand_s : index;
        end
    end

endmodule

// File: rtl/fix_conn_scheduler.sv
// Multi-host connection scheduler: arbitrates per-host connect/disconnect
// requests onto the single TOE request channel, tracks session state from
// the acknowledges and retries connects that time out.
module fix_conn_scheduler
    import fix_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] conn_req_i,
    input  logic [3:0] disc_req_i,
    input  logic       req_ready_i,
    input  logic       connected_i,
    input  logic [1:0] connected_host_addr_i,
    output logic       connect_req_o,
    output logic [1:0] connect_addr_o,
    output logic       disconnect_o,
    output logic [1:0] disconnect_host_num_o,
    output logic [3:0] host_connected_o,
    output logic [3:0] host_failed_o,
    output logic       busy_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    sched_state_t   state_r;
    host_addr_t     grant_r;
    host_addr_t     rr_ptr_r;
    logic [3:0]     disc_pend_r;
    logic [TW-1:0]  timer_r;
    logic [RW-1:0]  retry_cnt_r;

    logic           disc_any_s;
    host_addr_t     disc_idx_s;
    logic [3:0]     elig_s;
    logic           pick_valid_s;
    logic [1:0]     pick_idx_s;
    logic           ack_match_s;
    logic           timeout_s;
    logic           give_up_s;
    logic [3:0]     disc_clr_s;
    logic [3:0]     conn_set_s;
    logic [3:0]     conn_clr_s;
    logic [3:0]     fail_set_s;

    // Arbitration inputs and per-host bit updates derived from current state.
    assign disc_any_s  = |disc_pend_r;
    assign disc_idx_s  = lowest_set(disc_pend_r);
    assign elig_s      = conn_req_i & ~host_connected_o & ~host_failed_o & ~disc_pend_r;
    assign ack_match_s = connected_i && (connected_host_addr_i == grant_r);
    assign timeout_s   = (timer_r == TIMER_LAST);
    assign give_up_s   = (state_r == WAIT) && !ack_match_s && timeout_s &&
                         !(retry_cnt_r < RETRY_MAX);

    // A serviced disconnect clears its latch bit; a fresh pulse re-sets it below.
    assign disc_clr_s  = ((state_r == IDLE) && disc_any_s) ? host_onehot(disc_idx_s) : 4'b0000;
    assign conn_set_s  = ((state_r == WAIT) && ack_match_s) ? host_onehot(grant_r) : 4'b0000;
    assign conn_clr_s  = ((state_r == DISC) && disconnect_o && req_ready_i) ?
                         host_onehot(disconnect_host_num_o) : 4'b0000;
    assign fail_set_s  = give_up_s ? host_onehot(grant_r) : 4'b0000;

    fix_rr_pick u_rr_pick (
        .mask  (elig_s),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .index (pick_idx_s)
    );

    // Scheduler FSM with registered request outputs and per-host session state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r               <= IDLE;
            grant_r               <= 2'd0;
            rr_ptr_r              <= 2'd0;
            disc_pend_r           <= 4'b0000;
            timer_r               <= '0;
            retry_cnt_r           <= '0;
            connect_req_o         <= 1'b0;
            connect_addr_o        <= 2'd0;
            disconnect_o          <= 1'b0;
            disconnect_host_num_o <= 2'd0;
            host_connected_o      <= 4'b0000;
            host_failed_o         <= 4'b0000;
            busy_o                <= 1'b0;
        end else begin
            disc_pend_r      <= (disc_pend_r & ~disc_clr_s) | disc_req_i;
            host_connected_o <= (host_connected_o & ~conn_clr_s) | conn_set_s;
            // Failure flag is held only while the app keeps requesting.
            host_failed_o    <= (host_failed_o | fail_set_s) & conn_req_i;

            case (state_r)
                IDLE: begin
                    if (disc_any_s) begin
                        if (host_connected_o[disc_idx_s]) begin
                            state_r               <= DISC;
                            disconnect_o          <= 1'b1;
                            disconnect_host_num_o <= disc_idx_s;
                            busy_o                <= 1'b1;
                        end else begin
                            // Nothing to tear down: the latch bit is simply dropped.
                            state_r <= IDLE;
                            busy_o  <= 1'b0;
                        end
                    end else if (pick_valid_s) begin
                        state_r        <= CONN;
                        connect_req_o  <= 1'b1;
                        connect_addr_o <= pick_idx_s;
                        grant_r        <= pick_idx_s;
                        retry_cnt_r    <= '0;
                        busy_o         <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                CONN: begin
                    if (req_ready_i) begin
                        state_r       <= WAIT;
                        connect_req_o <= 1'b0;
                        timer_r       <= '0;
                    end else begin
                        connect_req_o <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ack_match_s) begin
                        // Acknowledge takes precedence over a coincident timeout.
                        state_r  <= IDLE;
                        rr_ptr_r <= grant_r + 2'd1;
                        busy_o   <= 1'b0;
                    end else if (timeout_s) begin
                        if (retry_cnt_r < RETRY_MAX) begin
                            state_r        <= CONN;
                            retry_cnt_r    <= retry_cnt_r + RW'(1);
                            connect_req_o  <= 1'b1;
                            connect_addr_o <= grant_r;
                        end else begin
                            state_r  <= IDLE;
                            rr_ptr_r <= grant_r + 2'd1;
                            busy_o   <= 1'b0;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                DISC: begin
                    if (req_ready_i) begin
                        state_r      <= IDLE;
                        disconnect_o <= 1'b0;
                        busy_o       <= 1'b0;
                    end else begin
                        disconnect_o <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    connect_req_o <= 1'b0;
                    disconnect_o  <= 1'b0;
                    busy_o        <= 1'b0;
                end
            endcase
        end
    end

endmodule
